// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: PC register, imem request FSM, decode handoff
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   nextPC[31:0]        next address from the next-PC adder, taken only at the decode handoff
//   curPC[31:0]         PC of the instruction being fetched or held
//   imem_req            read request, high only while fetching
//   imem_addr[31:0]     read address, always curPC
//   imem_ack            read completion; imem_rdata valid in the same cycle
//   imem_rdata[31:0]    fetched instruction word
//   instr[31:0]         registered instruction for decode
//   instr_valid         instr holds an unconsumed instruction
//   instr_ready         decode accepts instr
//   misalign            sticky: a non word-aligned nextPC was offered at handoff
//   fetch_cnt[31:0]     instructions handed to decode, wraps modulo 2^32

module pc_fetch (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] nextPC,
    output logic [31:0] curPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            curPC       <= 32'h0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            fetch_cnt   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // Handoff edge: the only place nextPC is looked at.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        fetch_cnt   <= fetch_cnt + 32'd1;
                        if (nextPC[1:0] == 2'b00) begin
                            curPC <= nextPC;
                            state <= FETCH;
                        end else begin
                            // curPC keeps the faulting instruction's address for debug.
                            misalign <= 1'b1;
                            state    <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    // Dead until reset; instr_valid was already cleared on entry.
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pure decode of the registered state: no input reaches imem_req combinationally.
    assign imem_req  = (state == FETCH);
    assign imem_addr = curPC;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 nextPC  input  32  next instruction address from the next-PC adder.
REQ-005 curPC  output  32  PC of the instruction currently held or being fetched; feeds the next-PC adder.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  32  read address; equals curPC.
REQ-008 imem_ack  input  1  memory completion; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr  output  32  registered instruction to decode.
REQ-011 instr_valid  output  1  instr holds an unconsumed instruction.
REQ-012 instr_ready  input  1  decode accepts instr.
REQ-013 misalign  output  1  sticky fault: nextPC was not word-aligned.
REQ-014 fetch_cnt  output  32  count of instructions handed to decode.

Function
REQ-015 The state machine SHALL have four states: IDLE, FETCH, HOLD, FAULT.
REQ-016 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-017 imem_req SHALL be 1 only in state FETCH, decoded from the registered state with no combinational path from any input.
REQ-018 imem_addr SHALL equal curPC at all times.
REQ-019 In FETCH, when imem_ack=1 at a clock edge:
- instr <= imem_rdata
- instr_valid <= 1
- next state HOLD.
REQ-020 In FETCH with imem_ack=0, the state SHALL remain FETCH, and imem_req and imem_addr SHALL stay stable.
REQ-021 imem_ack outside FETCH SHALL be ignored; it SHALL change no state, instr or counter.
REQ-022 In HOLD, instr and instr_valid=1 SHALL stay stable until instr_ready=1 is sampled.
REQ-023 On the HOLD edge with instr_ready=1, the block SHALL set instr_valid <= 0 and fetch_cnt <= fetch_cnt+1, with fetch_cnt wrapping modulo 2^32.
REQ-024 At that same edge, if nextPC[1:0]==2'b00, the block SHALL set curPC <= nextPC and go to FETCH.
REQ-025 At that same edge, if nextPC[1:0]!=2'b00, the block SHALL set misalign <= 1, leave curPC unchanged and go to FAULT.
REQ-026 nextPC SHALL be sampled only at the HOLD handoff edge; it SHALL be ignored in all other states.
REQ-027 FAULT SHALL hold imem_req=0 and instr_valid=0 and SHALL be left only by RST.
REQ-028 instr_ready in any state other than HOLD SHALL have no effect.
REQ-029 Best-case throughput SHALL be one instruction per 2 cycles (FETCH with ack, then HOLD with ready).

Reset
REQ-030 When RST=1 at an edge, the block SHALL set:
- state IDLE
- curPC 32'h0, instr 32'h0
- instr_valid 0, misalign 0
- fetch_cnt 32'h0.
REQ-031 While the registered state is IDLE, imem_req SHALL be 0.
REQ-032 The first request SHALL be made with imem_req=1 and imem_addr=0 in the second cycle after RST is released.
REQ-033 RST SHALL take priority over all other inputs in every state.
REQ-034 RST asserted mid-fetch (FETCH, ack pending) SHALL abandon the fetch, with imem_req=0 from the cycle after the reset edge.
REQ-035 An imem_ack arriving after such a reset SHALL be ignored.
REQ-036 No output SHALL be X after the first reset edge.

Verification
REQ-037 Reset, then zero-wait memory (ack=1 whenever req=1), instr_ready=1, nextPC=curPC+4 -> imem_addr sequence 0,4,8,12; instr_valid pulses every 2nd cycle; fetch_cnt=4 after 4 handoffs.
REQ-038 Wait states: ack delayed 3 cycles at addr 0x10 -> imem_req and imem_addr=0x10 held for 4 cycles; instr=rdata captured only on the ack edge.
REQ-039 Backpressure: instr_ready=0 for 5 cycles in HOLD with instr=0x8C220004 -> instr and instr_valid stable; no new request; curPC unchanged; fetch_cnt unchanged.
REQ-040 Misaligned target: nextPC=0x00400002 at handoff -> misalign=1, state FAULT, imem_req=0 permanently, curPC unchanged; RST clears misalign and restarts at 0.
REQ-041 Reset mid-fetch: RST=1 while FETCH at 0x20 with ack pending, then ack=1 one cycle later -> ack ignored, instr=0, instr_valid=0, next request at address 0.
REQ-042 Stray signals: ack=1 in HOLD/IDLE and instr_ready=1 in FETCH -> no change to instr, curPC or fetch_cnt.
